rslt_serializer: RTL

RSLT_SERIALIZER -- requirements
Module: rslt_serializer

---
 rtl/kan_axis_pkg.sv | 18 +
 rtl/rslt_serializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/kan_axis_pkg.sv
// Shared definitions for the result-stream AXIS blocks.
//   rslt_state_e : serializer state encoding (IDLE=0, SEND=1)
//   idx_width()  : width of a lane index for a given lane count (minimum 1)
package kan_axis_pkg;

    localparam int DEFAULT_RSLT_CHANNELS = 16;
    localparam int DEFAULT_BATCH_SIZE    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rslt_state_e;

    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/rslt_serializer.sv
// Wide-to-narrow AXI-Stream serializer for result beats.
// A wide beat of LANES words is captured into a holding register and emitted
// one word per cycle, lane 0 first.
//
// Ports
//   clk, rst                 : rising-edge clock, async active-high reset
//   s_axis_rslt_tdata/tkeep  : wide beat (lane 0 in the low bits) and byte enables
//   s_axis_rslt_tvalid/tready/tlast : wide-side handshake
//   m_axis_tdata/tkeep       : current lane word and its byte enables
//   m_axis_tvalid/tready/tlast : narrow-side handshake
//   busy                     : a captured beat is still being emitted
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | no beat held, ready for a new wide beat
// SEND    | beat held, presenting lane idx_q
module rslt_serializer
    import kan_axis_pkg::*;
#(
    parameter int LANES           = DEFAULT_RSLT_CHANNELS * DEFAULT_BATCH_SIZE,
    parameter int DATA_WIDTH      = 16,
    parameter int KEEP_WIDTH      = (DATA_WIDTH + 7) / 8,
    parameter int LAST_EVERY_BEAT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANES*DATA_WIDTH-1:0]      s_axis_rslt_tdata,
    input  logic [LANES*KEEP_WIDTH-1:0]      s_axis_rslt_tkeep,
    input  logic                             s_axis_rslt_tvalid,
    output logic                             s_axis_rslt_tready,
    input  logic                             s_axis_rslt_tlast,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             busy
);

    localparam int                IDX_W    = idx_width(LANES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);
    localparam logic              LAST_ALL = (LAST_EVERY_BEAT != 0);

    rslt_state_e                  state_q, state_d;
    logic [IDX_W-1:0]             idx_q;
    logic [LANES*DATA_WIDTH-1:0]  hold_data_q;
    logic [LANES*KEEP_WIDTH-1:0]  hold_keep_q;
    logic                         hold_last_q;

    logic                         at_last;
    logic                         in_xfer;
    logic                         out_xfer;
    logic [DATA_WIDTH-1:0]        lane_data;
    logic [KEEP_WIDTH-1:0]        lane_keep;

    assign at_last  = (idx_q == LAST_IDX);
    assign in_xfer  = s_axis_rslt_tvalid & s_axis_rslt_tready;
    assign out_xfer = m_axis_tvalid & m_axis_tready;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; a reload on the last word keeps us in SEND
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_xfer) state_d = ST_SEND;
            ST_SEND: if (out_xfer && at_last && !in_xfer) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs; tready is gated by rst so it reads 0 throughout reset
    always_comb begin
        s_axis_rslt_tready = 1'b0;
        m_axis_tvalid      = 1'b0;
        m_axis_tdata       = '0;
        m_axis_tkeep       = '0;
        m_axis_tlast       = 1'b0;
        busy               = 1'b0;
        case (state_q)
            ST_IDLE: s_axis_rslt_tready = ~rst;
            ST_SEND: begin
                s_axis_rslt_tready = ~rst & at_last & m_axis_tready;
                m_axis_tvalid      = 1'b1;
                m_axis_tdata       = lane_data;
                m_axis_tkeep       = lane_keep;
                m_axis_tlast       = at_last & (hold_last_q | LAST_ALL);
                busy               = 1'b1;
            end
            default: ;
        endcase
    end

    // lane select with constant part-select bases
    always_comb begin
        lane_data = '0;
        lane_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                lane_data = hold_data_q[i*DATA_WIDTH +: DATA_WIDTH];
                lane_keep = hold_keep_q[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    // holding register and lane index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
        end else if (in_xfer) begin
            idx_q       <= '0;
            hold_data_q <= s_axis_rslt_tdata;
            hold_keep_q <= s_axis_rslt_tkeep;
            hold_last_q <= s_axis_rslt_tlast;
        end else if (out_xfer) begin
            idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule
